// File: rtl/phy_types_pkg.sv
// Shared types and constants for the PHY receive packet path.
// The CRC-32 bit-step helper is used by phy_rx_crc32.
package phy_types_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        CRCCHK,
        DROP
    } rx_pkt_state_t;

    localparam logic [31:0] CRC32_POLY  = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT  = 32'hFFFF_FFFF;
    localparam int          MAX_LEN_DEF = 16;
    localparam int          LEN_W       = $clog2(MAX_LEN_DEF + 1);

    // One MSB-first CRC-32 step, no reflection.
    function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic din);
        return {crc[30:0], 1'b0} ^ ((crc[31] ^ din) ? CRC32_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/phy_rx_crc32.sv
// CRC-32 accumulator: one FLIT_W-bit word per en, restarting from the init value when init is high.
// Instantiated only when PHY_RX_PKT_CTRL_CRC_CHECK_EN is defined.
module phy_rx_crc32
    import phy_types_pkg::*;
#(
    parameter int FLIT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              en,
    input  logic [FLIT_W-1:0] data,
    output logic [31:0]       crc
);

    logic [31:0] crc_next;

    always_comb begin
        crc_next = init ? CRC32_INIT : crc;
        for (int i = FLIT_W - 1; i >= 0; i--) begin
            crc_next = crc32_bit(crc_next, data[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC32_INIT;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/phy_rx_pkt_ctrl.sv
// Receive packet sequencer: frames sop/header/payload/CRC flits and forwards them through an elastic FIFO.
// Optional CRC checking is enabled by defining PHY_RX_PKT_CTRL_CRC_CHECK_EN; otherwise crc_ok is 1 at every pkt_done.
module phy_rx_pkt_ctrl
    import phy_types_pkg::*;
#(
    parameter int FLIT_W     = 32,
    parameter int MAX_LEN    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rx_sop,
    input  logic              rx_valid,
    input  logic [FLIT_W-1:0] rx_flit,
    input  logic              rx_err,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_last,
    output logic              pkt_done,
    output logic              crc_ok,
    output logic              err_out,
    output logic              busy
);

    localparam int                  LEN_BITS  = $clog2(MAX_LEN + 1);
    localparam int                  PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                  CNT_W     = PTR_W + 1;
    localparam logic [LEN_BITS-1:0] LEN_MAX   = LEN_BITS'(MAX_LEN);
    localparam logic [LEN_BITS-1:0] LEN_ONE   = LEN_BITS'(1);
    localparam logic [CNT_W-1:0]    FIFO_FULL = CNT_W'(FIFO_DEPTH);

    rx_pkt_state_t       state, state_nxt;
    logic [LEN_BITS-1:0] cnt, cnt_nxt, hdr_len;
    logic                err_nxt, done_nxt, ok_nxt;
    logic                push, push_last, pop, full, overflow, crc_match;
    logic [FLIT_W:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;

    assign hdr_len  = rx_flit[LEN_BITS-1:0];
    assign full     = (count == FIFO_FULL);
    // A flit transfers on a cycle where out_valid and out_ready are both high; once raised,
    // out_valid and the presented flit hold until that transfer happens.
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign overflow  = full && !pop;
    assign {out_last, out_flit} = mem[rd_ptr];
    assign busy      = (state != IDLE);

`ifdef PHY_RX_PKT_CTRL_CRC_CHECK_EN
    logic [31:0] crc_val;

    phy_rx_crc32 #(.FLIT_W(FLIT_W)) u_crc (
        .clk  (CLK),
        .rst  (RST),
        .init (state == HDR),
        .en   (push),
        .data (rx_flit),
        .crc  (crc_val)
    );

    assign crc_match = (rx_flit == FLIT_W'(crc_val));
`else
    assign crc_match = 1'b1;
`endif

    // rx_err outranks rx_sop, which outranks any flit arriving in the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        ok_nxt    = 1'b0;
        push      = 1'b0;
        push_last = 1'b0;
        if (rx_err && state != IDLE) begin
            err_nxt   = 1'b1;
            state_nxt = DROP;
        end else if (rx_sop) begin
            err_nxt   = (state == HDR) || (state == PAYLOAD) || (state == CRCCHK);
            state_nxt = HDR;
        end else if (rx_valid) begin
            case (state)
                HDR: begin
                    if (hdr_len == '0 || hdr_len > LEN_MAX || overflow) begin
                        err_nxt   = 1'b1;
                        state_nxt = DROP;
                    end else begin
                        push      = 1'b1;
                        cnt_nxt   = hdr_len;
                        state_nxt = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (overflow) begin
                        err_nxt   = 1'b1;
                        state_nxt = DROP;
                    end else begin
                        push      = 1'b1;
                        push_last = (cnt == LEN_ONE);
                        cnt_nxt   = cnt - LEN_ONE;
                        if (cnt == LEN_ONE) state_nxt = CRCCHK;
                    end
                end
                CRCCHK: begin
                    done_nxt  = 1'b1;
                    ok_nxt    = crc_match;
                    state_nxt = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            err_out  <= 1'b0;
            pkt_done <= 1'b0;
            crc_ok   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            err_out  <= err_nxt;
            pkt_done <= done_nxt;
            crc_ok   <= ok_nxt;
        end
    end

    // On push+pop while full, wr_ptr equals rd_ptr and the slot being overwritten is the one leaving.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_last, rx_flit};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule
